// File: rtl/thread_dispatch_pkg.sv
// Shared types for the issue stage of the 4-thread / 4-ALU core.
//   NUM_Threads / NUM_ALUs : core geometry
//   TID_IDLE               : thread id shown on a lane that carries nothing
//   thread_id_t            : 3-bit thread id (wide enough to encode TID_IDLE)
//   ins_entry_t            : one queued instruction word with its PC
package thread_dispatch_pkg;
    localparam int NUM_Threads = 4;
    localparam int NUM_ALUs    = 4;
    localparam int TID_W       = 3;

    typedef logic [TID_W-1:0] thread_id_t;

    localparam thread_id_t TID_IDLE = thread_id_t'(NUM_Threads);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ins_entry_t;
endpackage

// File: rtl/thread_ins_queue.sv
// Per-thread instruction FIFO.
//   clk, rst   : clock, async active-high reset
//   enq        : write enq_data at the tail (caller guarantees room)
//   deq        : pop the head (caller guarantees count > 0)
//   flush      : drop everything; overrides enq/deq
//   count      : number of valid entries
//   head       : oldest entry (meaningful only when count > 0)
module thread_ins_queue
    import thread_dispatch_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  ins_entry_t    enq_data,
    input  logic          deq,
    input  logic          flush,
    output logic [CW-1:0] count,
    output ins_entry_t    head
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);

    ins_entry_t    mem [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // Storage needs no reset; when full with enq+deq together, the write
    // lands in the slot whose old contents are being issued this cycle.
    always_ff @(posedge clk) begin
        if (enq && !flush) mem[wr_ptr] <= enq_data;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/thread_dispatch.sv
// Issue stage: queues fetched words per thread and grants up to NUM_ALUs
// threads per cycle to ready lanes, round-robin from rr_ptr.
//   ins/pc_in        : fetched word + PC per thread (ins==0 is a bubble)
//   jump_en          : per-thread redirect, flushes that thread's queue
//   thread_busy      : thread may not issue this cycle
//   alu_ready        : lane can accept an instruction
//   hold             : registered back-pressure to fetch
//   dispatch_threads : thread id issued per lane (TID_IDLE when idle)
//   alu_valid/ins/pc : registered lane payload
//   overflow_err     : sticky, set when a word hit a full queue
module thread_dispatch
    import thread_dispatch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_Threads-1:0][31:0]     ins,
    input  logic [NUM_Threads-1:0][31:0]     pc_in,
    input  logic [NUM_Threads-1:0]           jump_en,
    input  logic [NUM_Threads-1:0]           thread_busy,
    input  logic [NUM_ALUs-1:0]              alu_ready,
    output logic [NUM_Threads-1:0]           hold,
    output logic [NUM_ALUs-1:0][TID_W-1:0]   dispatch_threads,
    output logic [NUM_ALUs-1:0]              alu_valid,
    output logic [NUM_ALUs-1:0][31:0]        alu_ins,
    output logic [NUM_ALUs-1:0][31:0]        alu_pc,
    output logic                             overflow_err
);
    localparam int CW  = $clog2(QDEPTH + 1);
    localparam int RRW = (NUM_Threads > 1) ? $clog2(NUM_Threads) : 1;
    localparam logic [CW-1:0] QD    = CW'(QDEPTH);
    localparam logic [CW-1:0] QD_M1 = CW'(QDEPTH - 1);

    logic [CW-1:0]          count [NUM_Threads];
    ins_entry_t             head  [NUM_Threads];
    logic [NUM_Threads-1:0] eligible, deq, enq_req, enq_ok, ovf_now, hold_d;
    logic [RRW-1:0]         rr_ptr, rr_d;

    logic [NUM_ALUs-1:0][TID_W-1:0] tid_d;
    logic [NUM_ALUs-1:0]            vld_d;
    logic [NUM_ALUs-1:0][31:0]      ins_d, pc_d;

    for (genvar g = 0; g < NUM_Threads; g++) begin : g_q
        thread_ins_queue #(.QDEPTH(QDEPTH), .CW(CW)) u_q (
            .clk      (clk),
            .rst      (rst),
            .enq      (enq_ok[g]),
            .enq_data ('{pc: pc_in[g], ins: ins[g]}),
            .deq      (deq[g]),
            .flush    (jump_en[g]),
            .count    (count[g]),
            .head     (head[g])
        );
        assign eligible[g] = (count[g] != '0) && !thread_busy[g] && !jump_en[g];
    end

    // Round-robin allocation: each eligible thread, in scan order, takes the
    // lowest free ready lane; once lanes run out later threads simply miss.
    always_comb begin
        int   t;
        logic found;
        t         = 0;
        found     = 1'b0;
        deq       = '0;
        tid_d     = {NUM_ALUs{TID_IDLE}};
        vld_d     = '0;
        ins_d     = '0;
        pc_d      = '0;
        rr_d      = rr_ptr;
        for (int i = 0; i < NUM_Threads; i++) begin
            t = int'(rr_ptr) + i;
            if (t >= NUM_Threads) t = t - NUM_Threads;
            found = 1'b0;
            if (eligible[t]) begin
                for (int a = 0; a < NUM_ALUs; a++) begin
                    if (!found && alu_ready[a] && !vld_d[a]) begin
                        found    = 1'b1;
                        vld_d[a] = 1'b1;
                        tid_d[a] = thread_id_t'(t);
                        ins_d[a] = head[t].ins;
                        pc_d[a]  = head[t].pc;
                        deq[t]   = 1'b1;
                        rr_d     = RRW'((t + 1) % NUM_Threads);
                    end
                end
            end
        end
    end

    // Enqueue acceptance and next-cycle hold. A full queue still takes a word
    // if it pops the same cycle. hold leaves one slot for the word fetch
    // already has in flight.
    always_comb begin
        logic [CW-1:0] post;
        post = '0;
        for (int t = 0; t < NUM_Threads; t++) begin
            enq_req[t] = (ins[t] != 32'h0) && !jump_en[t];
            enq_ok[t]  = enq_req[t] && ((count[t] < QD) || ((count[t] == QD) && deq[t]));
            ovf_now[t] = enq_req[t] && !enq_ok[t];
            post       = jump_en[t] ? '0 : count[t] + CW'(enq_ok[t]) - CW'(deq[t]);
            hold_d[t]  = !jump_en[t] && (post >= QD_M1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr           <= '0;
            hold             <= '0;
            dispatch_threads <= {NUM_ALUs{TID_IDLE}};
            alu_valid        <= '0;
            alu_ins          <= '0;
            alu_pc           <= '0;
            overflow_err     <= 1'b0;
        end else begin
            rr_ptr           <= rr_d;
            hold             <= hold_d;
            dispatch_threads <= tid_d;
            alu_valid        <= vld_d;
            alu_ins          <= ins_d;
            alu_pc           <= pc_d;
            overflow_err     <= overflow_err | (|ovf_now);
        end
    end
endmodule

// File: tb/tb_thread_dispatch.sv
// Directed bench for thread_dispatch: reset state, single issue, round-robin
// with partial lane readiness, overflow/hold, jump flush, full enq+deq and
// asynchronous reset mid-operation.
module tb_thread_dispatch;
    logic             clk = 1'b0;
    logic             rst;
    logic [3:0][31:0] ins, pc_in;
    logic [3:0]       jump_en, thread_busy, alu_ready;
    logic [3:0]       hold;
    logic [3:0][2:0]  dispatch_threads;
    logic [3:0]       alu_valid;
    logic [3:0][31:0] alu_ins, alu_pc;
    logic             overflow_err;

    int vecs = 0;
    int errs = 0;

    localparam logic [11:0] ALL_IDLE = {3'd4, 3'd4, 3'd4, 3'd4};

    thread_dispatch #(.QDEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .ins              (ins),
        .pc_in            (pc_in),
        .jump_en          (jump_en),
        .thread_busy      (thread_busy),
        .alu_ready        (alu_ready),
        .hold             (hold),
        .dispatch_threads (dispatch_threads),
        .alu_valid        (alu_valid),
        .alu_ins          (alu_ins),
        .alu_pc           (alu_pc),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ins = '0; pc_in = '0; jump_en = '0; thread_busy = '0; alu_ready = 4'hF;
        #12;
        chk("rst_valid", alu_valid, 4'b0);
        chk("rst_tid", dispatch_threads, ALL_IDLE);
        chk("rst_hold", hold, 4'b0);
        chk("rst_ovf", overflow_err, 1'b0);
        chk("rst_pc", alu_pc, 128'h0);

        // single word on thread 0
        rst = 1'b0;
        ins[0] = 32'h00500093; pc_in[0] = 32'h0;
        step();
        chk("t1_no_bypass", alu_valid, 4'b0);
        chk("t1_hold", hold, 4'b0001);
        ins[0] = '0;
        step();
        chk("t1_tid", dispatch_threads, {3'd4, 3'd4, 3'd4, 3'd0});
        chk("t1_valid", alu_valid, 4'b0001);
        chk("t1_ins", alu_ins[0], 32'h00500093);
        chk("t1_pc", alu_pc[0], 32'h0);
        chk("t1_hold_clr", hold, 4'b0);

        // rr_ptr is 1: a lone thread-1 grant moves it to 2
        ins[1] = 32'h11; pc_in[1] = 32'h100;
        step();
        ins[1] = '0;
        step();
        chk("t2_pre_tid", dispatch_threads, {3'd4, 3'd4, 3'd4, 3'd1});

        // all four threads hold one word, lanes 0 and 2 ready
        alu_ready = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            ins[t] = 32'h200 + t; pc_in[t] = 32'h40 + 4 * t;
        end
        step();
        chk("t2_load_idle", alu_valid, 4'b0);
        ins = '0;
        step();
        chk("t2_tid", dispatch_threads, {3'd4, 3'd3, 3'd4, 3'd2});
        chk("t2_valid", alu_valid, 4'b0101);
        chk("t2_pc", {alu_pc[2], alu_pc[0]}, {32'h4C, 32'h48});
        chk("t2_hold", hold, 4'b0011);
        alu_ready = 4'hF;
        step();
        chk("t2_retained_tid", dispatch_threads, {3'd4, 3'd4, 3'd1, 3'd0});
        chk("t2_retained_pc", {alu_pc[1], alu_pc[0]}, {32'h44, 32'h40});

        // thread 2 fills while busy, then jumps with a word present
        thread_busy = 4'b0100;
        ins[2] = 32'h22; pc_in[2] = 32'h20;
        step();
        pc_in[2] = 32'h24;
        step();
        chk("t4_hold_full", hold, 4'b0100);
        jump_en = 4'b0100; thread_busy = '0; ins[2] = 32'h23; pc_in[2] = 32'h28;
        step();
        chk("t4_hold_jump", hold, 4'b0);
        chk("t4_no_issue", alu_valid, 4'b0);
        chk("t4_ovf", overflow_err, 1'b0);
        jump_en = '0; ins[2] = '0;
        step();
        chk("t4_flushed", dispatch_threads, ALL_IDLE);

        // thread 3 full, granted and fed the same cycle
        thread_busy = 4'b1000;
        ins[3] = 32'h33; pc_in[3] = 32'h30;
        step();
        pc_in[3] = 32'h34;
        step();
        thread_busy = '0; pc_in[3] = 32'h38;
        step();
        chk("t5_tid", dispatch_threads, {3'd4, 3'd4, 3'd4, 3'd3});
        chk("t5_pc0", alu_pc[0], 32'h30);
        chk("t5_ovf", overflow_err, 1'b0);
        chk("t5_hold", hold, 4'b1000);
        ins[3] = '0;
        step();
        chk("t5_pc1", alu_pc[0], 32'h34);
        step();
        chk("t5_pc2", alu_pc[0], 32'h38);
        chk("t5_empty_hold", hold, 4'b0);

        // thread 1 fed every cycle while busy -> overflow, then drains in order
        thread_busy = 4'b0010;
        ins[1] = 32'hA1; pc_in[1] = 32'h4;
        step();
        chk("t3_hold1", hold, 4'b0010);
        pc_in[1] = 32'h8;
        step();
        chk("t3_ovf_pre", overflow_err, 1'b0);
        chk("t3_hold2", hold, 4'b0010);
        pc_in[1] = 32'hC;
        step();
        chk("t3_ovf", overflow_err, 1'b1);
        ins[1] = '0; thread_busy = '0;
        step();
        chk("t3_drain0", {dispatch_threads[0], alu_pc[0]}, {3'd1, 32'h4});
        step();
        chk("t3_drain1", {dispatch_threads[0], alu_pc[0]}, {3'd1, 32'h8});
        step();
        chk("t3_drained", alu_valid, 4'b0);
        chk("t3_ovf_sticky", overflow_err, 1'b1);

        // asynchronous reset with thread 2 still queued
        thread_busy = 4'b0100;
        ins[0] = 32'hB0; pc_in[0] = 32'h50;
        ins[2] = 32'hB2; pc_in[2] = 32'h60;
        step();
        ins = '0;
        step();
        chk("t6_pre_valid", alu_valid, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", alu_valid, 4'b0);
        chk("t6_async_tid", dispatch_threads, ALL_IDLE);
        chk("t6_async_ovf", overflow_err, 1'b0);
        chk("t6_async_pc", alu_pc, 128'h0);
        rst = 1'b0; thread_busy = '0;
        step();
        chk("t6_no_stale", alu_valid, 4'b0);
        chk("t6_no_stale_hold", hold, 4'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
